// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler sharing one memory port among NUM_REQS requesters, with a read-credit cap.
// Optional performance counters are enabled by defining MEM_SCHED_PERF_EN.
module mem_port_scheduler #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
`ifdef MEM_SCHED_PERF_EN
  , parameter int PERF_CTR_BITS = 32
`endif
  , localparam int REQ_SEL_BITS  = $clog2(NUM_REQS)
  , localparam int MEM_TAG_WIDTH = TAG_WIDTH + REQ_SEL_BITS
  , localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              in_req_valid,
  input  logic [NUM_REQS-1:0]              in_req_rw,
  input  logic [NUM_REQS*BE_WIDTH-1:0]     in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    in_req_tag,
  output logic [NUM_REQS-1:0]              in_req_ready,
  output logic [NUM_REQS-1:0]              in_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]    in_rsp_tag,
  input  logic [NUM_REQS-1:0]              in_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BE_WIDTH-1:0]              mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [MEM_TAG_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [MEM_TAG_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy
`ifdef MEM_SCHED_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]       perf_reads
  , output logic [PERF_CTR_BITS-1:0]       perf_writes
  , output logic [PERF_CTR_BITS-1:0]       perf_latency
`endif
);

  localparam int PCNT_W = $clog2(MAX_PENDING + 1);

  logic                     r_mem_req_valid;
  logic                     r_mem_req_rw;
  logic [BE_WIDTH-1:0]      r_mem_req_byteen;
  logic [ADDR_WIDTH-1:0]    r_mem_req_addr;
  logic [DATA_WIDTH-1:0]    r_mem_req_data;
  logic [MEM_TAG_WIDTH-1:0] r_mem_req_tag;
  logic [REQ_SEL_BITS-1:0]  r_rr_ptr;
  logic [PCNT_W-1:0]        r_pending;

  logic [NUM_REQS-1:0]      w_eligible;
  logic [REQ_SEL_BITS-1:0]  w_grant;
  logic [REQ_SEL_BITS-1:0]  w_next_ptr;
  logic [REQ_SEL_BITS-1:0]  w_rsp_idx;
  logic                     w_found;
  logic                     w_can_load;
  logic                     w_accept;
  logic                     w_inc;
  logic                     w_dec;
  logic                     w_rsp_fire;
  logic                     w_rsp_hit;

  // Writes ignore the read-credit cap; eligibility sees only the registered count.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_eligible[i] = in_req_valid[i] && (in_req_rw[i] || (r_pending < PCNT_W'(MAX_PENDING)));
    end
  end

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx     = (int'(r_rr_ptr) + k) % NUM_REQS;
      w_grant = (!w_found && w_eligible[idx]) ? REQ_SEL_BITS'(idx) : w_grant;
      w_found = w_found || w_eligible[idx];
    end
  end

  assign w_can_load   = !r_mem_req_valid || mem_req_ready;
  assign w_accept     = w_found && w_can_load;
  assign w_next_ptr   = (w_grant == REQ_SEL_BITS'(NUM_REQS - 1)) ? '0 : (w_grant + REQ_SEL_BITS'(1));
  assign in_req_ready = w_accept ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << w_grant) : '0;
  assign w_inc        = w_accept && !in_req_rw[w_grant];
  assign w_rsp_fire   = mem_rsp_valid && mem_rsp_ready;
  assign w_dec        = w_rsp_fire && (r_pending != '0);

  // Route the memory response to the requester named in the tag LSBs; unknown indices are dropped.
  always_comb begin
    w_rsp_idx     = mem_rsp_tag[REQ_SEL_BITS-1:0];
    in_rsp_valid  = '0;
    mem_rsp_ready = 1'b1;
    w_rsp_hit     = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_rsp_idx == REQ_SEL_BITS'(i)) begin
        in_rsp_valid[i] = mem_rsp_valid;
        mem_rsp_ready   = in_rsp_ready[i];
        w_rsp_hit       = 1'b1;
      end else begin
        in_rsp_valid[i] = 1'b0;
      end
    end
  end

  assign in_rsp_data = {NUM_REQS{mem_rsp_data}};
  assign in_rsp_tag  = {NUM_REQS{mem_rsp_tag[MEM_TAG_WIDTH-1:REQ_SEL_BITS]}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req_valid <= 1'b0;
    end else if (w_can_load) begin
      r_mem_req_valid <= w_found;
    end else begin
      r_mem_req_valid <= r_mem_req_valid;
    end
  end

  // Payload needs no reset: it is qualified by r_mem_req_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_req_rw     <= in_req_rw[w_grant];
      r_mem_req_byteen <= in_req_byteen[int'(w_grant)*BE_WIDTH +: BE_WIDTH];
      r_mem_req_addr   <= in_req_addr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
      r_mem_req_data   <= in_req_data[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
      r_mem_req_tag    <= {in_req_tag[int'(w_grant)*TAG_WIDTH +: TAG_WIDTH], w_grant};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_pending <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_next_ptr;
      end
      if (w_inc && !w_dec) begin
        r_pending <= r_pending + PCNT_W'(1);
      end else if (!w_inc && w_dec) begin
        r_pending <= r_pending - PCNT_W'(1);
      end
    end
  end

  assign mem_req_valid  = r_mem_req_valid;
  assign mem_req_rw     = r_mem_req_rw;
  assign mem_req_byteen = r_mem_req_byteen;
  assign mem_req_addr   = r_mem_req_addr;
  assign mem_req_data   = r_mem_req_data;
  assign mem_req_tag    = r_mem_req_tag;
  assign busy           = r_mem_req_valid || (r_pending != '0);

`ifdef MEM_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_reads;
  logic [PERF_CTR_BITS-1:0] r_perf_writes;
  logic [PERF_CTR_BITS-1:0] r_perf_latency;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_reads   <= '0;
      r_perf_writes  <= '0;
      r_perf_latency <= '0;
    end else begin
      if (r_mem_req_valid && mem_req_ready && !r_mem_req_rw) begin
        r_perf_reads <= r_perf_reads + PERF_CTR_BITS'(1);
      end
      if (r_mem_req_valid && mem_req_ready && r_mem_req_rw) begin
        r_perf_writes <= r_perf_writes + PERF_CTR_BITS'(1);
      end
      r_perf_latency <= r_perf_latency + PERF_CTR_BITS'(r_pending);
    end
  end

  assign perf_reads   = r_perf_reads;
  assign perf_writes  = r_perf_writes;
  assign perf_latency = r_perf_latency;
`endif

  mem_port_scheduler_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .rsp_valid    (mem_rsp_valid),
    .rsp_fire     (w_rsp_fire),
    .pending_zero (r_pending == '0),
    .rsp_idx_bad  (!w_rsp_hit)
  );

endmodule

// Protocol checks on the memory response side.
module mem_port_scheduler_chk (
  input logic clk,
  input logic reset,
  input logic rsp_valid,
  input logic rsp_fire,
  input logic pending_zero,
  input logic rsp_idx_bad
);

  a_rsp_without_pending: assert property (@(posedge clk) disable iff (reset) !(rsp_fire && pending_zero));
  a_rsp_bad_index:       assert property (@(posedge clk) disable iff (reset) !(rsp_valid && rsp_idx_bad));

endmodule
